// File: rtl/crc_pkg.sv
// -----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the framed CRC engine:
//   - crc_state_e    : frame FSM encoding (IDLE / BUSY / DONE)
//   - CRC*_POLY      : common generator polynomials (implicit top term omitted)
//   - BEATS_MAX      : saturation value of the per-frame beat counter
//   - reverse_bits() : reverses the low w bits of a value (w <= 32)
// -----------------------------------------------------------------------------
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } crc_state_e;

  localparam logic [7:0]  CRC8_POLY        = 8'h07;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;

  localparam logic [15:0] BEATS_MAX = 16'hFFFF;

  // Full 32-bit reversal, then shift the w interesting bits down to the LSBs.
  // Keeps every bit select constant, whatever w is.
  function automatic logic [31:0] reverse_bits(input logic [31:0] v, input int w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r >> (32 - w);
  endfunction

endpackage

// File: rtl/crc_step_comb.sv
// -----------------------------------------------------------------------------
// crc_step_comb
// Purely combinational CRC update over one DATA_WIDTH-bit beat, direct
// (non-augmented) form, one shift/XOR step per data bit.
// Ports:
//   crc_i  [CRC_WIDTH-1:0]  register value before the beat
//   data_i [DATA_WIDTH-1:0] beat payload
//   crc_o  [CRC_WIDTH-1:0]  register value after all DATA_WIDTH bit steps
// Bit order: MSB first when REFLECT_IN=0, LSB first when REFLECT_IN=1.
// -----------------------------------------------------------------------------
module crc_step_comb #(
  parameter int                   CRC_WIDTH  = 8,
  parameter logic [CRC_WIDTH-1:0] POLYNOMIAL = CRC_WIDTH'(8'h07),
  parameter int                   DATA_WIDTH = 8,
  parameter bit                   REFLECT_IN = 1'b0
) (
  input  logic [CRC_WIDTH-1:0]  crc_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CRC_WIDTH-1:0]  crc_o
);

  always_comb begin
    logic [CRC_WIDTH-1:0] c;
    logic                 d;
    logic                 fb;
    c  = crc_i;
    d  = 1'b0;
    fb = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      d  = REFLECT_IN ? data_i[i] : data_i[DATA_WIDTH-1-i];
      fb = c[CRC_WIDTH-1] ^ d;
      c  = (c << 1) ^ (fb ? POLYNOMIAL : '0);
    end
    crc_o = c;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// -----------------------------------------------------------------------------
// crc_stream_engine
// Framed CRC engine: accepts one DATA_WIDTH-bit beat per cycle between
// in_sop/in_eop and presents one result per frame with valid/ready.
// Ports:
//   clk, rst           clock; synchronous active-low reset
//   in_valid/in_ready  input beat handshake (in_ready low only while a result waits)
//   in_data            beat payload
//   in_sop/in_eop      frame delimiters, meaningful only with in_valid
//   out_valid/out_ready result handshake
//   out_crc            final CRC after optional reflection and XOR_OUT
//   out_zero           raw register was zero at frame end (receive-side check)
//   out_beats          accepted beats in the frame, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int                   CRC_WIDTH   = 8,
  parameter logic [CRC_WIDTH-1:0] POLYNOMIAL  = CRC_WIDTH'(CRC8_POLY),
  parameter logic [CRC_WIDTH-1:0] INIT        = '0,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT     = '0,
  parameter int                   DATA_WIDTH  = 8,
  parameter bit                   REFLECT_IN  = 1'b0,
  parameter bit                   REFLECT_OUT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CRC_WIDTH-1:0]  out_crc,
  output logic                  out_zero,
  output logic [15:0]           out_beats
);

  crc_state_e           state_q, state_d;
  logic [CRC_WIDTH-1:0] crc_q, crc_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [CRC_WIDTH-1:0] out_crc_q, out_crc_d;
  logic                 out_zero_q, out_zero_d;
  logic [15:0]          out_beats_q, out_beats_d;

  logic                 accept;
  logic [CRC_WIDTH-1:0] step_seed;
  logic [CRC_WIDTH-1:0] step_crc;
  logic                 capture;
  logic [CRC_WIDTH-1:0] final_crc;

  assign in_ready  = (state_q != ST_DONE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;

  // A frame always starts from INIT: either the first beat out of IDLE or an
  // sop that abandons the frame in progress.
  assign step_seed = ((state_q == ST_IDLE) || in_sop) ? INIT : crc_q;

  crc_step_comb #(
    .CRC_WIDTH  (CRC_WIDTH),
    .POLYNOMIAL (POLYNOMIAL),
    .DATA_WIDTH (DATA_WIDTH),
    .REFLECT_IN (REFLECT_IN)
  ) u_step (
    .crc_i  (step_seed),
    .data_i (in_data),
    .crc_o  (step_crc)
  );

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        // Beats without sop in IDLE belong to no frame and are dropped.
        if (accept && in_sop) begin
          crc_d   = step_crc;
          cnt_d   = 16'd1;
          state_d = in_eop ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept) begin
          crc_d = step_crc;
          if (in_sop) begin
            cnt_d = 16'd1;
          end else begin
            cnt_d = (cnt_q == BEATS_MAX) ? cnt_q : cnt_q + 16'd1;
          end
          if (in_eop) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result is captured on the same edge that enters DONE, from the
  // register value that edge is about to store.
  assign capture = (state_q != ST_DONE) && (state_d == ST_DONE);

  always_comb begin
    final_crc = (REFLECT_OUT ? CRC_WIDTH'(reverse_bits(32'(crc_d), CRC_WIDTH)) : crc_d) ^ XOR_OUT;
    out_crc_d   = out_crc_q;
    out_zero_d  = out_zero_q;
    out_beats_d = out_beats_q;
    if (capture) begin
      out_crc_d   = final_crc;
      out_zero_d  = (crc_d == '0);
      out_beats_d = cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      crc_q       <= INIT;
      cnt_q       <= '0;
      out_crc_q   <= '0;
      out_zero_q  <= 1'b0;
      out_beats_q <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      out_crc_q   <= out_crc_d;
      out_zero_q  <= out_zero_d;
      out_beats_q <= out_beats_d;
    end
  end

  assign out_crc   = out_crc_q;
  assign out_zero  = out_zero_q;
  assign out_beats = out_beats_q;

endmodule
